// File: rtl/mini68k_fetch_biu.sv
// Prefetch-queue fetch port responder: runs one 68000-style asynchronous read per request.
// Define MINI68K_FETCH_BIU_PERF_EN to add the perf_fetches/perf_waits counters.
module mini68k_fetch_biu #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned SETUP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [23:0] fetch_addr,
  input  logic        flush,
  output logic [15:0] fetch_data,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic [22:0] bus_addr,
  output logic        bus_as_n,
  output logic        bus_uds_n,
  output logic        bus_lds_n,
  output logic        bus_rw,
  input  logic [15:0] bus_data_in,
  input  logic        bus_dtack_n,
  input  logic        bus_berr_n
`ifdef MINI68K_FETCH_BIU_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_waits
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_DONE, S_ERR, S_RECOVER, S_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        strobe_n_q, strobe_n_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  dtack_sync_q, berr_sync_q;
  logic        dtack_s, berr_s;

  assign dtack_s = dtack_sync_q[1];
  assign berr_s  = berr_sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && fetch_req) begin
          if (fetch_addr[0]) begin
            state_d = S_HALTED;
          end else begin
            addr_d  = fetch_addr[23:1];
            cnt_d   = '0;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'(SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (flush) abort_d = 1'b1;
        if (!berr_s) begin
          state_d = S_ERR;
        end else if (!dtack_s) begin
          state_d = S_LATCH;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LATCH: begin
        // An aborted cycle skips DONE entirely so neither data nor done leak out.
        if (abort_q || flush) begin
          state_d = S_RECOVER;
        end else begin
          data_d  = bus_data_in;
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_RECOVER;
      S_ERR:     state_d = (abort_q || flush) ? S_RECOVER : S_HALTED;
      S_RECOVER: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      S_HALTED:  if (flush) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    strobe_n_d = !(state_d == S_WAIT || state_d == S_LATCH);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      strobe_n_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dtack_sync_q <= '1;
      berr_sync_q  <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strobe_n_q   <= strobe_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dtack_sync_q <= {dtack_sync_q[0], bus_dtack_n};
      berr_sync_q  <= {berr_sync_q[0], bus_berr_n};
    end
  end

  assign fetch_data = data_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;
  assign bus_addr   = addr_q;
  assign bus_as_n   = strobe_n_q;
  assign bus_uds_n  = strobe_n_q;
  assign bus_lds_n  = strobe_n_q;
  assign bus_rw     = 1'b1;

`ifdef MINI68K_FETCH_BIU_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_waits_q, perf_waits_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_waits_d   = perf_waits_q;
    if (state_q == S_DONE) perf_fetches_d = perf_fetches_q + 32'd1;
    if (state_q == S_WAIT && dtack_s) perf_waits_d = perf_waits_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetches_q <= '0;
      perf_waits_q   <= '0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_waits_q   <= perf_waits_d;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_waits   = perf_waits_q;
`endif

endmodule

// File: tb/tb_mini68k_fetch_biu.sv
// Directed bench for mini68k_fetch_biu with hand-computed cycle-accurate expectations.
module tb_mini68k_fetch_biu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [23:0] fetch_addr = '0;
  logic        flush = 1'b0;
  logic [15:0] fetch_data;
  logic        fetch_done;
  logic        fetch_err;
  logic [22:0] bus_addr;
  logic        bus_as_n;
  logic        bus_uds_n;
  logic        bus_lds_n;
  logic        bus_rw;
  logic [15:0] bus_data_in = '0;
  logic        bus_dtack_n = 1'b1;
  logic        bus_berr_n = 1'b1;
`ifdef MINI68K_FETCH_BIU_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_waits;
`endif

  int checks = 0;
  int errors = 0;

  mini68k_fetch_biu #(.TIMEOUT(16), .SETUP(1)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
    .fetch_data(fetch_data), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .bus_addr(bus_addr), .bus_as_n(bus_as_n), .bus_uds_n(bus_uds_n), .bus_lds_n(bus_lds_n),
    .bus_rw(bus_rw), .bus_data_in(bus_data_in), .bus_dtack_n(bus_dtack_n), .bus_berr_n(bus_berr_n)
`ifdef MINI68K_FETCH_BIU_PERF_EN
    , .perf_fetches(perf_fetches), .perf_waits(perf_waits)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst_as_n", 32'(bus_as_n), 32'd1);
    check("rst_uds_n", 32'(bus_uds_n), 32'd1);
    check("rst_lds_n", 32'(bus_lds_n), 32'd1);
    check("rst_rw", 32'(bus_rw), 32'd1);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_data", 32'(fetch_data), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    ticks(2);
    rst = 1'b0;

    // zero-wait read, dtack held low long enough to pass the synchronizer
    bus_dtack_n = 1'b0;
    bus_data_in = 16'h4E71;
    ticks(3);
    fetch_req = 1'b1; fetch_addr = 24'h000400;            // T0
    tick();                                               // T1
    check("zw_t1_addr", 32'(bus_addr), 32'h000200);
    check("zw_t1_as_n", 32'(bus_as_n), 32'd1);
    tick();                                               // T2
    check("zw_t2_as_n", 32'(bus_as_n), 32'd0);
    check("zw_t2_uds_n", 32'(bus_uds_n), 32'd0);
    check("zw_t2_lds_n", 32'(bus_lds_n), 32'd0);
    tick();                                               // T3
    check("zw_t3_as_n", 32'(bus_as_n), 32'd0);
    check("zw_t3_done", 32'(fetch_done), 32'd0);
    tick();                                               // T4
    check("zw_t4_done", 32'(fetch_done), 32'd1);
    check("zw_t4_data", 32'(fetch_data), 32'h4E71);
    check("zw_t4_as_n", 32'(bus_as_n), 32'd1);
    fetch_req = 1'b0;
    tick();                                               // T5
    check("zw_t5_done", 32'(fetch_done), 32'd0);
    check("zw_t5_as_n", 32'(bus_as_n), 32'd1);
    tick();
    check("zw_t6_as_n", 32'(bus_as_n), 32'd1);
    check("zw_t6_data_held", 32'(fetch_data), 32'h4E71);

    // five wait states
    bus_dtack_n = 1'b1;
    bus_data_in = 16'h1234;
    ticks(3);
    fetch_req = 1'b1; fetch_addr = 24'h001000;            // T0
    ticks(2);                                             // T2
    check("ws_t2_as_n", 32'(bus_as_n), 32'd0);
    ticks(3);                                             // T5
    bus_dtack_n = 1'b0;
    ticks(3);                                             // T8
    check("ws_t8_done", 32'(fetch_done), 32'd0);
    check("ws_t8_as_n", 32'(bus_as_n), 32'd0);
    tick();                                               // T9
    check("ws_t9_done", 32'(fetch_done), 32'd1);
    check("ws_t9_data", 32'(fetch_data), 32'h1234);
`ifdef MINI68K_FETCH_BIU_PERF_EN
    check("ws_perf_waits", perf_waits, 32'd5);
`endif
    fetch_req = 1'b0;
    tick();
    check("ws_t10_done", 32'(fetch_done), 32'd0);

    // timeout after 16 WAIT cycles
    bus_dtack_n = 1'b1;
    ticks(3);
    fetch_req = 1'b1; fetch_addr = 24'h000800;            // T0
    ticks(2);                                             // T2
    check("to_t2_as_n", 32'(bus_as_n), 32'd0);
    ticks(15);                                            // T17
    check("to_t17_as_n", 32'(bus_as_n), 32'd0);
    tick();                                               // T18
    check("to_t18_as_n", 32'(bus_as_n), 32'd1);
    check("to_t18_err", 32'(fetch_err), 32'd0);
    tick();                                               // T19
    check("to_t19_err", 32'(fetch_err), 32'd1);
    fetch_req = 1'b0;
    ticks(5);
    check("to_err_held", 32'(fetch_err), 32'd1);
    check("to_halt_as_n", 32'(bus_as_n), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("to_flush_err", 32'(fetch_err), 32'd0);
    check("to_done", 32'(fetch_done), 32'd0);

    // bus error pulse during WAIT
    fetch_req = 1'b1; fetch_addr = 24'h000A00;            // T0
    ticks(2);                                             // T2
    check("be_t2_as_n", 32'(bus_as_n), 32'd0);
    bus_berr_n = 1'b0;
    tick();                                               // T3
    bus_berr_n = 1'b1;
    tick();                                               // T4
    check("be_t4_as_n", 32'(bus_as_n), 32'd0);
    tick();                                               // T5
    check("be_t5_as_n", 32'(bus_as_n), 32'd1);
    check("be_t5_err", 32'(fetch_err), 32'd0);
    check("be_t5_done", 32'(fetch_done), 32'd0);
    tick();                                               // T6
    check("be_t6_err", 32'(fetch_err), 32'd1);
    check("be_t6_done", 32'(fetch_done), 32'd0);
    fetch_req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("be_flush_err", 32'(fetch_err), 32'd0);

    // odd address
    fetch_req = 1'b1; fetch_addr = 24'h000401;            // T0
    tick();                                               // T1
    check("odd_t1_err", 32'(fetch_err), 32'd1);
    check("odd_t1_as_n", 32'(bus_as_n), 32'd1);
    tick();                                               // T2
    check("odd_t2_err", 32'(fetch_err), 32'd1);
    check("odd_t2_as_n", 32'(bus_as_n), 32'd1);
    check("odd_addr_kept", 32'(bus_addr), 32'h000500);
    fetch_req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("odd_flush_err", 32'(fetch_err), 32'd0);

    // flush during WAIT, dtack arrives later
    bus_data_in = 16'hBEEF;
    fetch_req = 1'b1; fetch_addr = 24'h000C00;            // T0
    ticks(2);                                             // T2
    check("fl_t2_as_n", 32'(bus_as_n), 32'd0);
    flush = 1'b1;
    tick();                                               // T3
    flush = 1'b0; bus_dtack_n = 1'b0; fetch_addr = 24'h000E00;
    check("fl_t3_as_n", 32'(bus_as_n), 32'd0);
    ticks(3);                                             // T6
    check("fl_t6_as_n", 32'(bus_as_n), 32'd0);
    check("fl_t6_done", 32'(fetch_done), 32'd0);
    tick();                                               // T7
    check("fl_t7_as_n", 32'(bus_as_n), 32'd1);
    check("fl_t7_done", 32'(fetch_done), 32'd0);
    check("fl_t7_err", 32'(fetch_err), 32'd0);
    tick();                                               // T8
    check("fl_t8_done", 32'(fetch_done), 32'd0);
    check("fl_t8_data", 32'(fetch_data), 32'h1234);
    check("fl_t8_addr", 32'(bus_addr), 32'h000600);
    tick();                                               // T9
    check("fl_t9_addr", 32'(bus_addr), 32'h000700);
    check("fl_t9_as_n", 32'(bus_as_n), 32'd1);
    ticks(3);                                             // T12
    check("fl_t12_done", 32'(fetch_done), 32'd1);
    check("fl_t12_data", 32'(fetch_data), 32'hBEEF);
    fetch_req = 1'b0;
    tick();

    // asynchronous reset mid-cycle
    bus_dtack_n = 1'b1;
    ticks(3);
    fetch_req = 1'b1; fetch_addr = 24'h002000;
    ticks(2);
    check("rm_as_n_low", 32'(bus_as_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rm_as_n", 32'(bus_as_n), 32'd1);
    check("rm_uds_n", 32'(bus_uds_n), 32'd1);
    check("rm_done", 32'(fetch_done), 32'd0);
    check("rm_addr", 32'(bus_addr), 32'd0);
    fetch_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rm_after_as_n", 32'(bus_as_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
